serial_addsub: RTL and testbench

Multi-cycle add/subtract unit that processes wide operands one 4-bit nibble per clock through a single 4-bit adder slice, chaining the carry in a register between cycles. It sits between an operand source (valid/ready) and a result consumer (valid/ready). It gives the datapath wide add/sub, a unsigned carry/borrow, signed overflow and zero flags, at the area cost of one nibble adder.

---
 rtl/serial_addsub_pkg.sv | 21 ++
 rtl/nibble_add.sv | 14 +
 rtl/serial_addsub.sv | 114 +++++++++++
 tb/tb_serial_addsub.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int NIBBLE_W = 4;

    // Signed saturation bounds for a w-bit two's-complement value (w <= 64).
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/nibble_add.sv
// Combinational 4-bit adder slice shared by every nibble of a serial operation.
module nibble_add
    import serial_addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    assign {cout, sum} = (NIBBLE_W+1)'(a) + (NIBBLE_W+1)'(b) + (NIBBLE_W+1)'(cin);

endmodule

// File: rtl/serial_addsub.sv
// Wide add/sub computed one nibble per clock through a single nibble_add slice.
// Optional signed saturation of the result: define SERIAL_ADDSUB_SAT_EN.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                       sub,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] result,
    output logic                       carry,
    output logic                       overflow,
    output logic                       zero
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    sa_state_t state, state_n;

    logic [W-1:0]        a_q, b_q, raw_q, raw_n, res_n;
    logic                sub_q, cy_q, ovf_n;
    logic [IW-1:0]       idx_q;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;

    nibble_add u_add (
        .a    (a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
        .b    (b_q[idx_q*NIBBLE_W +: NIBBLE_W]),
        .cin  (cy_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Raw result as it will look once the current nibble is written back.
    always_comb begin
        raw_n = raw_q;
        raw_n[idx_q*NIBBLE_W +: NIBBLE_W] = nib_sum;
        ovf_n = (a_q[W-1] == b_q[W-1]) && (raw_n[W-1] != a_q[W-1]);
`ifdef SERIAL_ADDSUB_SAT_EN
        if (ovf_n)
            res_n = a_q[W-1] ? W'(sat_min(W)) : W'(sat_max(W));
        else
            res_n = raw_n;
`else
        res_n = raw_n;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid)      state_n = RUN;
            RUN:     if (idx_q == LAST) state_n = DONE;
            DONE:    if (out_ready)     state_n = IDLE;
            default:                    state_n = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            raw_q    <= '0;
            sub_q    <= 1'b0;
            cy_q     <= 1'b0;
            idx_q    <= '0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    // B is pre-inverted and the carry seeded with sub: A + ~B + 1.
                    a_q   <= a;
                    b_q   <= b ^ {W{sub}};
                    sub_q <= sub;
                    cy_q  <= sub;
                    idx_q <= '0;
                end
                RUN: begin
                    raw_q <= raw_n;
                    cy_q  <= nib_cout;
                    idx_q <= idx_q + IW'(1);
                    if (idx_q == LAST) begin
                        result   <= res_n;
                        carry    <= nib_cout ^ sub_q;
                        overflow <= ovf_n;
                        zero     <= (raw_n == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed + random bench for serial_addsub against an integer-arithmetic reference.
module tb_serial_addsub;

    localparam int NIBBLES = 4;
    localparam int W       = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry, overflow, zero;

    int total = 0;
    int bad   = 0;

    serial_addsub #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os,
                         output logic [W-1:0] r, output logic c, output logic o, output logic z);
        int sa, sb, sr, ur;
        sa = $signed(oa);
        sb = $signed(ob);
        ur = os ? int'(oa) - int'(ob) : int'(oa) + int'(ob);
        sr = os ? sa - sb : sa + sb;
        r  = ur[W-1:0];
        c  = os ? (oa < ob) : (ur > 65535);
        o  = (sr > 32767) || (sr < -32768);
        z  = (r == '0);
`ifdef SERIAL_ADDSUB_SAT_EN
        if (o) r = (sa < 0) ? 16'h8000 : 16'h7FFF;
`endif
    endtask

    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os,
                         input int hold);
        logic [W-1:0] er;
        logic ec, eo, ez;
        int n;
        model(oa, ob, os, er, ec, eo, ez);
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_before", 32'(in_ready), 32'd1);
        a = oa; b = ob; sub = os; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
        n = 1;
        while (!out_valid && n < 20) begin
            check("no_early_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1; n++;
        end
        check("latency", 32'(n), 32'(NIBBLES + 1));
        check("result",   32'(result),   32'(er));
        check("carry",    32'(carry),    32'(ec));
        check("overflow", 32'(overflow), 32'(eo));
        check("zero",     32'(zero),     32'(ez));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
            check("hold_valid",  32'(out_valid), 32'd1);
            check("hold_ready",  32'(in_ready),  32'd0);
            check("hold_result", 32'(result),    32'(er));
            check("hold_flags",  {29'd0, carry, overflow, zero}, {29'd0, ec, eo, ez});
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_ready", 32'(in_ready),  32'd1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs",   {12'd0, result, 1'b0, carry, overflow, zero}, 32'd0);

        do_op(16'h1234, 16'h0FFF, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1);
        do_op(16'h0005, 16'h0007, 1'b1, 0);
        do_op(16'h0007, 16'h0007, 1'b1, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 0);
        do_op(16'h8000, 16'h0001, 1'b1, 0);
        do_op(16'h8000, 16'h8000, 1'b0, 0);
        do_op(16'hA5C3, 16'h3C5A, 1'b1, 6);

        // Abort mid-operation: reset lands in the second RUN cycle.
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_outputs",   {12'd0, result, 1'b0, carry, overflow, zero}, 32'd0);
        repeat (6) begin
            @(posedge clk); #1;
            check("abort_no_output", 32'(out_valid), 32'd0);
        end
        do_op(16'h0001, 16'h0001, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom;
            if (i % 8 == 0) rb = ra;
            do_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
